// File: rtl/load_store_unit_if.sv
// ---------------------------------------------------------------------------
// load_store_unit_if
// Bundles the request/response handshake between the execute stage and the
// load/store unit, plus the word-organised data memory bus.
//   req_*   : request from the core (valid/ready handshake)
//   resp_*  : single-cycle completion pulse back to the core
//   mem_*   : word-indexed memory port (read data returns one cycle later)
// Modports:
//   master : core/memory side (drives requests and mem_rdata)
//   slave  : the load/store unit itself
// ---------------------------------------------------------------------------
interface load_store_unit_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
);
   logic             req_valid;
   logic             req_ready;
   logic             req_write;
   logic [2:0]       req_funct3;
   logic [WIDTH-1:0] req_addr;
   logic [WIDTH-1:0] req_wdata;
   logic             resp_valid;
   logic [WIDTH-1:0] resp_rdata;
   logic             resp_error;
   logic [DEPTH-3:0] mem_addr;
   logic             mem_rd;
   logic             mem_wr;
   logic [WIDTH-1:0] mem_wdata;
   logic [WIDTH-1:0] mem_rdata;

   modport master (
      output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_error,
             mem_addr, mem_rd, mem_wr, mem_wdata
   );

   modport slave (
      input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_error,
             mem_addr, mem_rd, mem_wr, mem_wdata
   );
endinterface

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Multi-cycle RISC-V load/store unit in front of a word-organised memory.
// One request at a time; sub-word stores are read-modify-write; loads are
// lane-extracted and sign/zero-extended; misaligned or illegal requests are
// answered with an error response and never touch memory.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : load_store_unit_if.slave (request, response and memory bus)
// ---------------------------------------------------------------------------
module load_store_unit #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
) (
   input logic                clk,
   input logic                rst,
   load_store_unit_if.slave   bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_CAP,
      S_WR,
      S_RESP
   } state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   state_t           state;
   state_t           state_nxt;

   logic             write_q;
   logic [2:0]       funct3_q;
   logic [DEPTH-1:0] addr_q;
   logic [WIDTH-1:0] wdata_q;
   logic             err_q;
   logic [WIDTH-1:0] rdata_q;
   logic [WIDTH-1:0] wdata_mem_q;

   logic             accept;
   logic             req_err;
   logic             unused_addr_bits;

   // Address bits above DEPTH are ignored so the memory wraps.
   assign unused_addr_bits = ^bus.req_addr[WIDTH-1:DEPTH];

   // Request legality: funct3 set depends on direction, then alignment.
   function automatic logic check_error(input logic wr, input logic [2:0] f3,
                                        input logic [1:0] lane);
      logic err;
      err = 1'b0;
      case (f3)
         F3_B:         err = 1'b0;
         F3_H:         err = lane[0];
         F3_W:         err = (lane != 2'b00);
         F3_BU, F3_HU: err = wr | ((f3 == F3_HU) & lane[0]);
         default:      err = 1'b1;
      endcase
      return err;
   endfunction

   // Pick the addressed byte/half out of the word and extend it.
   function automatic logic [WIDTH-1:0] extract_load(input logic [2:0] f3,
                                                     input logic [1:0] lane,
                                                     input logic [WIDTH-1:0] word);
      logic [7:0]       byte_v;
      logic [15:0]      half_v;
      logic [WIDTH-1:0] res;
      byte_v = 8'(word >> (8 * lane));
      half_v = lane[1] ? word[31:16] : word[15:0];
      case (f3)
         F3_B:    res = {{(WIDTH-8){byte_v[7]}}, byte_v};
         F3_BU:   res = {{(WIDTH-8){1'b0}}, byte_v};
         F3_H:    res = {{(WIDTH-16){half_v[15]}}, half_v};
         F3_HU:   res = {{(WIDTH-16){1'b0}}, half_v};
         default: res = word;
      endcase
      return res;
   endfunction

   // Overlay store data onto the old word for sub-word stores.
   function automatic logic [WIDTH-1:0] merge_store(input logic [2:0] f3,
                                                    input logic [1:0] lane,
                                                    input logic [WIDTH-1:0] old,
                                                    input logic [WIDTH-1:0] wd);
      logic [WIDTH-1:0] res;
      res = old;
      case (f3)
         F3_B: begin
            case (lane)
               2'd0:    res[7:0]   = wd[7:0];
               2'd1:    res[15:8]  = wd[7:0];
               2'd2:    res[23:16] = wd[7:0];
               default: res[31:24] = wd[7:0];
            endcase
         end
         F3_H: begin
            if (lane[1]) res[31:16] = wd[15:0];
            else         res[15:0]  = wd[15:0];
         end
         default: res = wd;
      endcase
      return res;
   endfunction

   assign accept  = bus.req_valid && bus.req_ready;
   assign req_err = check_error(bus.req_write, bus.req_funct3, bus.req_addr[1:0]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
               if (req_err)
                  state_nxt = S_RESP;
               else if (bus.req_write && bus.req_funct3 == F3_W)
                  state_nxt = S_WR;
               else
                  state_nxt = S_RD;
            end
         end
         S_RD:    state_nxt = S_CAP;
         S_CAP:   state_nxt = write_q ? S_WR : S_RESP;
         S_WR:    state_nxt = S_RESP;
         S_RESP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Request latch on accept; CAP turns memory data into either the load
   // result or the merged store word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         write_q     <= 1'b0;
         funct3_q    <= 3'b000;
         addr_q      <= '0;
         wdata_q     <= '0;
         err_q       <= 1'b0;
         rdata_q     <= '0;
         wdata_mem_q <= '0;
      end else begin
         if (state == S_IDLE && accept) begin
            write_q  <= bus.req_write;
            funct3_q <= bus.req_funct3;
            addr_q   <= bus.req_addr[DEPTH-1:0];
            wdata_q  <= bus.req_wdata;
            err_q    <= req_err;
            // SW skips the read, so its write data is ready straight away.
            if (bus.req_write && !req_err && bus.req_funct3 == F3_W)
               wdata_mem_q <= bus.req_wdata;
         end
         if (state == S_CAP) begin
            if (write_q)
               wdata_mem_q <= merge_store(funct3_q, addr_q[1:0], bus.mem_rdata, wdata_q);
            else
               rdata_q <= extract_load(funct3_q, addr_q[1:0], bus.mem_rdata);
         end
      end
   end

   // Strobes are pure state decodes so an async reset drops them at once.
   assign bus.req_ready  = (state == S_IDLE) && !rst;
   assign bus.resp_valid = (state == S_RESP);
   assign bus.resp_error = (state == S_RESP) && err_q;
   assign bus.resp_rdata = rdata_q;
   assign bus.mem_rd     = (state == S_RD);
   assign bus.mem_wr     = (state == S_WR);
   assign bus.mem_wdata  = wdata_mem_q;
   assign bus.mem_addr   = (state == S_IDLE) ? '0 : addr_q[DEPTH-1:2];

endmodule
